// File: rtl/orb_reader.sv
// Read side of the orbital packer: drains one frame of words from the two
// packer RAMs on serializer request and toggles SW at each completed frame.
`timescale 1ns/1ps
module orb_reader #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned FRAME_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rdReq,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2,
  output logic [ADDR_W-1:0] RdAddr,
  output logic [DATA_W-1:0] oWord,
  output logic [7:0]        oByte,
  output logic              oValid,
  output logic              busy,
  output logic              frameDone,
  output logic              SW,
  output logic              err
);

  localparam int unsigned K_W = ADDR_W + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_WORDS - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_REQ = 2'd1;
  localparam logic [1:0] S_READ     = 2'd2;
  localparam logic [1:0] S_LATCH    = 2'd3;

  logic [1:0]        r_req_sync;
  logic              r_req_prev;
  logic              w_req_evt;

  logic [1:0]        r_state,  w_state_nxt;
  logic [K_W-1:0]    r_k,      w_k_nxt;
  logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
  logic              r_sel,    w_sel_nxt;
  logic [DATA_W-1:0] r_word,   w_word_nxt;
  logic [7:0]        r_byte,   w_byte_nxt;
  logic              r_valid,  w_valid_nxt;
  logic              r_busy,   w_busy_nxt;
  logic              r_done,   w_done_nxt;
  logic              r_sw,     w_sw_nxt;
  logic              r_err,    w_err_nxt;
  logic [DATA_W-1:0] w_data;

  // rdReq is asynchronous: two-flop synchroniser plus an edge-detect stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_sync <= 2'b00;
      r_req_prev <= 1'b0;
    end else begin
      r_req_sync <= {r_req_sync[0], rdReq};
      r_req_prev <= r_req_sync[1];
    end
  end

  assign w_req_evt = r_req_sync[1] & ~r_req_prev;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_addr  <= '0;
      r_sel   <= 1'b0;
      r_word  <= '0;
      r_byte  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sw    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_addr  <= w_addr_nxt;
      r_sel   <= w_sel_nxt;
      r_word  <= w_word_nxt;
      r_byte  <= w_byte_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_sw    <= w_sw_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and next-output logic; strobes default low every cycle
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_addr_nxt  = r_addr;
    w_sel_nxt   = r_sel;
    w_word_nxt  = r_word;
    w_byte_nxt  = r_byte;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_sw_nxt    = r_sw;
    w_err_nxt   = r_err;
    w_data      = r_sel ? rdData2 : rdData1;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_k_nxt     = '0;
          w_addr_nxt  = '0;
          w_busy_nxt  = 1'b1;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_WAIT_REQ;
        end
      end
      S_WAIT_REQ: begin
        if (w_req_evt) begin
          w_addr_nxt  = r_k[ADDR_W-1:0];
          w_sel_nxt   = r_k[0];
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (w_req_evt) w_err_nxt = 1'b1;
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        if (w_req_evt) w_err_nxt = 1'b1;
        w_word_nxt  = w_data;
        w_byte_nxt  = w_data[10:3];
        w_valid_nxt = 1'b1;
        if (r_k == K_LAST) begin
          w_k_nxt     = '0;
          w_done_nxt  = 1'b1;
          w_sw_nxt    = ~r_sw;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_k_nxt     = r_k + K_W'(1);
          w_state_nxt = S_WAIT_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign RdAddr    = r_addr;
  assign oWord     = r_word;
  assign oByte     = r_byte;
  assign oValid    = r_valid;
  assign busy      = r_busy;
  assign frameDone = r_done;
  assign SW        = r_sw;
  assign err       = r_err;

endmodule
